// File: rtl/esfa_pkg.sv
// Shared ESFA sequencer types: opcode limits, FSM state and response flags.
// Latency: n/a (types only). Backpressure: n/a.
// Imported by the sequencer, its interface and the testbench.
package esfa_pkg;

    localparam logic [7:0] OP_NOP = 8'd8;
    localparam logic [7:0] OP_MAX = 8'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       result_bool;
        logic [7:0] value;
        logic       err;
        logic       timeout;
    } rsp_flags_t;

endpackage

// File: rtl/esfa_op_sequencer_if.sv
// Host command, array drive and host response bundle for the ESFA sequencer.
// Latency: n/a (wires only). Backpressure: cmd_ready/rsp_ready valid-ready pairs.
// slave = sequencer view, master = host plus array view.
interface esfa_op_sequencer_if #(parameter int CNT_W = 16);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_op;
    logic [7:0]       cmd_index;
    logic [7:0]       cmd_value;
    logic [7:0]       cmd_metadata;
    logic             cmd_is_meta;

    logic [7:0]       arr_selector;
    logic [7:0]       arr_new_index;
    logic [7:0]       arr_new_value;
    logic [7:0]       arr_metadata;
    logic             arr_is_metadata;
    logic             arr_opdone;
    logic             arr_result_bool;
    logic [7:0]       arr_result_value;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_bool;
    logic [7:0]       rsp_value;
    logic             rsp_err;
    logic             rsp_timeout;
    logic [CNT_W-1:0] rsp_cycles;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_index, cmd_value, cmd_metadata, cmd_is_meta,
        output cmd_ready,
        output arr_selector, arr_new_index, arr_new_value, arr_metadata, arr_is_metadata,
        input  arr_opdone, arr_result_bool, arr_result_value,
        output rsp_valid, rsp_bool, rsp_value, rsp_err, rsp_timeout, rsp_cycles, busy,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_index, cmd_value, cmd_metadata, cmd_is_meta,
        input  cmd_ready,
        input  arr_selector, arr_new_index, arr_new_value, arr_metadata, arr_is_metadata,
        output arr_opdone, arr_result_bool, arr_result_value,
        input  rsp_valid, rsp_bool, rsp_value, rsp_err, rsp_timeout, rsp_cycles, busy,
        output rsp_ready
    );

endinterface

// File: rtl/esfa_sat_counter.sv
// Saturating up-counter with clear; clear+inc together loads 1.
// Latency: 1 cycle (registered count). Backpressure: none, holds at all-ones.
// Clears only via clr or async reset.
module esfa_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? {{(W-1){1'b0}}, 1'b1} : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/esfa_op_sequencer.sv
// One-at-a-time command sequencer for the ESFA array; optional ESFA_SEQ_STATS_EN adds op/timeout stats.
// Latency: >=3 cycles accept->rsp_valid (accept, ISSUE, WAIT); illegal opcodes respond next cycle.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
module esfa_op_sequencer
    import esfa_pkg::*;
#(
    parameter logic [7:0] IDLE_OP        = OP_NOP,
    parameter logic [7:0] MAX_OP         = OP_MAX,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    esfa_op_sequencer_if.slave  bus
`ifdef ESFA_SEQ_STATS_EN
    ,
    output logic [15:0]         stat_ops,
    output logic [7:0]          stat_timeouts
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    seq_state_t       state;
    rsp_flags_t       rsp_q;
    logic [CNT_W-1:0] rsp_cycles_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       sel_q, idx_q, val_q, meta_q;
    logic             is_meta_q;

    logic accept, legal, at_tmo, cnt_inc, rsp_hs;

    assign accept  = bus.cmd_valid && (state == ST_IDLE);
    assign legal   = (bus.cmd_op <= MAX_OP);
    assign at_tmo  = (cnt == TMO);
    assign rsp_hs  = (state == ST_RESP) && bus.rsp_ready;
    assign cnt_inc = (accept && legal) || (state == ST_ISSUE) ||
                     ((state == ST_WAIT) && !bus.arr_opdone && !at_tmo);

    // Cleared on every accept; an illegal opcode leaves it at 0.
    esfa_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (cnt_inc),
        .count (cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sel_q        <= IDLE_OP;
            idx_q        <= '0;
            val_q        <= '0;
            meta_q       <= '0;
            is_meta_q    <= 1'b0;
            rsp_q        <= '0;
            rsp_cycles_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            sel_q     <= bus.cmd_op;
                            idx_q     <= bus.cmd_index;
                            val_q     <= bus.cmd_value;
                            meta_q    <= bus.cmd_metadata;
                            is_meta_q <= bus.cmd_is_meta;
                            state     <= ST_ISSUE;
                        end else begin
                            rsp_q        <= '{result_bool: 1'b0, value: 8'h00, err: 1'b1, timeout: 1'b0};
                            rsp_cycles_q <= '0;
                            state        <= ST_RESP;
                        end
                    end
                end
                // opdone is deliberately not sampled here: it may be left over from the previous op.
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.arr_opdone || at_tmo) begin
                        if (bus.arr_opdone) begin
                            rsp_q <= '{result_bool: bus.arr_result_bool, value: bus.arr_result_value,
                                       err: 1'b0, timeout: 1'b0};
                        end else begin
                            rsp_q <= '{result_bool: 1'b0, value: 8'h00, err: 1'b0, timeout: 1'b1};
                        end
                        rsp_cycles_q <= cnt;
                        sel_q        <= IDLE_OP;
                        idx_q        <= '0;
                        val_q        <= '0;
                        meta_q       <= '0;
                        is_meta_q    <= 1'b0;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready       = (state == ST_IDLE);
    assign bus.busy            = (state != ST_IDLE);
    assign bus.rsp_valid       = (state == ST_RESP);
    assign bus.rsp_bool        = rsp_q.result_bool;
    assign bus.rsp_value       = rsp_q.value;
    assign bus.rsp_err         = rsp_q.err;
    assign bus.rsp_timeout     = rsp_q.timeout;
    assign bus.rsp_cycles      = rsp_cycles_q;
    assign bus.arr_selector    = sel_q;
    assign bus.arr_new_index   = idx_q;
    assign bus.arr_new_value   = val_q;
    assign bus.arr_metadata    = meta_q;
    assign bus.arr_is_metadata = is_meta_q;

`ifdef ESFA_SEQ_STATS_EN
    esfa_sat_counter #(.W(16)) u_stat_ops (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (rsp_hs && !rsp_q.err),
        .count (stat_ops)
    );

    esfa_sat_counter #(.W(8)) u_stat_timeouts (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (rsp_hs && rsp_q.timeout),
        .count (stat_timeouts)
    );
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Randomized self-checking bench for esfa_op_sequencer (TIMEOUT_CYCLES=10), with a transaction-level model.
// Build with ESFA_SEQ_STATS_EN defined to also check the stats counters.
module tb_esfa_op_sequencer;
    import esfa_pkg::*;

    localparam int TMO = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_ops = 0;
    int   exp_tmo = 0;

    always #5 clk = ~clk;

    esfa_op_sequencer_if bus();
`ifdef ESFA_SEQ_STATS_EN
    logic [15:0] stat_ops;
    logic [7:0]  stat_timeouts;
`endif

    esfa_op_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ESFA_SEQ_STATS_EN
        ,
        .stat_ops      (stat_ops),
        .stat_timeouts (stat_timeouts)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_lines(input string name);
        checks++;
        if (bus.arr_selector !== 8'd8 || bus.arr_new_index !== 8'd0 || bus.arr_new_value !== 8'd0 ||
            bus.arr_metadata !== 8'd0 || bus.arr_is_metadata !== 1'b0)
            begin
            errors++;
            $display("FAIL %s arr got sel=%0d idx=%h val=%h meta=%h ism=%b want sel=8 rest 0",
                     name, bus.arr_selector, bus.arr_new_index, bus.arr_new_value,
                     bus.arr_metadata, bus.arr_is_metadata);
        end
    endtask

    // Model: legal op finishing k cycles after ISSUE reports k+1 cycles unless k+1 exceeds the
    // timeout, in which case it reports TMO cycles with the timeout flag; illegal ops report err, 0 cycles.
    task automatic run_op(input logic [7:0] op, input logic [7:0] idx, input logic [7:0] val,
                          input logic [7:0] meta, input logic ism, input int k, input bit stale,
                          input logic rb, input logic [7:0] rv, input int stall);
        bit         legal, exp_to;
        int         exp_c, c;
        logic       exp_b;
        logic [7:0] exp_v;
        logic [15:0] exp_cyc;
        legal   = (op <= 8'd7);
        exp_to  = legal && (k + 1 > TMO);
        exp_c   = !legal ? 0 : (exp_to ? TMO : k + 1);
        exp_b   = legal && !exp_to && rb;
        exp_v   = (legal && !exp_to) ? rv : 8'h00;
        exp_cyc = 16'(exp_c);

        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_before_cmd got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_index    = idx;
        bus.cmd_value    = val;
        bus.cmd_metadata = meta;
        bus.cmd_is_meta  = ism;
        step();
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 8'($urandom);
        bus.cmd_index    = 8'($urandom);
        bus.cmd_value    = 8'($urandom);
        bus.cmd_metadata = 8'($urandom);
        bus.cmd_is_meta  = 1'($urandom);

        c = 0;
        if (legal) begin
            while (bus.rsp_valid !== 1'b1 && c < TMO + 5) begin
                checks++;
                if ({bus.arr_selector, bus.arr_new_index, bus.arr_new_value, bus.arr_metadata,
                     bus.arr_is_metadata} !== {op, idx, val, meta, ism}) begin
                    errors++;
                    $display("FAIL arr_hold c=%0d got %h want %h", c,
                             {bus.arr_selector, bus.arr_new_index, bus.arr_new_value,
                              bus.arr_metadata, bus.arr_is_metadata}, {op, idx, val, meta, ism});
                end
                bus.arr_opdone       = (c == k) || (stale && c == 0);
                bus.arr_result_bool  = (c == k) ? rb : 1'($urandom);
                bus.arr_result_value = (c == k) ? rv : 8'($urandom);
                step();
                c++;
            end
            bus.arr_opdone = 1'b0;
        end
        checks++;
        if (c != exp_c) begin
            errors++;
            $display("FAIL rsp_latency op=%0d got %0d want %0d cycles after issue", op, c, exp_c);
        end

        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_bool !== exp_b || bus.rsp_value !== exp_v ||
                bus.rsp_err !== !legal || bus.rsp_timeout !== exp_to || bus.rsp_cycles !== exp_cyc)
                begin
                errors++;
                $display("FAIL rsp op=%0d s=%0d got v=%b b=%b val=%h err=%b to=%b cyc=%0d want v=1 b=%b val=%h err=%b to=%b cyc=%0d",
                         op, s, bus.rsp_valid, bus.rsp_bool, bus.rsp_value, bus.rsp_err,
                         bus.rsp_timeout, bus.rsp_cycles, exp_b, exp_v, !legal, exp_to, exp_cyc);
            end
            check_idle_lines("rsp_arr_idle");
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL rsp_ready_busy got cmd_ready=%b busy=%b want 0 1", bus.cmd_ready, bus.busy);
            end
            if (s < stall) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 8'($urandom_range(0, 7));
                step();
            end
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake got rsp_valid=%b cmd_ready=%b busy=%b want 0 1 0",
                     bus.rsp_valid, bus.cmd_ready, bus.busy);
        end
        if (legal && exp_ops < 65535) exp_ops++;
        if (exp_to && exp_tmo < 255) exp_tmo++;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_index = 0; bus.cmd_value = 0;
        bus.cmd_metadata = 0; bus.cmd_is_meta = 0; bus.arr_opdone = 0;
        bus.arr_result_bool = 0; bus.arr_result_value = 0; bus.rsp_ready = 0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_idle_lines("reset_arr");
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got cmd_ready=%b rsp_valid=%b busy=%b want 1 0 0",
                     bus.cmd_ready, bus.rsp_valid, bus.busy);
        end
        checks++;
        if ({bus.rsp_bool, bus.rsp_value, bus.rsp_err, bus.rsp_timeout, bus.rsp_cycles} !== 27'd0) begin
            errors++;
            $display("FAIL reset_rsp got %h want 0",
                     {bus.rsp_bool, bus.rsp_value, bus.rsp_err, bus.rsp_timeout, bus.rsp_cycles});
        end
        step();
    endtask

    task automatic test_basic();
        run_op(8'd3, 8'd5, 8'h2A, 8'h00, 1'b0, 4, 1'b0, 1'b1, 8'h2A, 0);
        run_op(8'd0, 8'h11, 8'h22, 8'h33, 1'b1, 2, 1'b0, 1'b0, 8'h5C, 0);
    endtask

    task automatic test_illegal();
        run_op(8'd9, 8'd1, 8'd2, 8'd3, 1'b1, 1, 1'b0, 1'b1, 8'hFF, 0);
        run_op(8'd255, 8'd7, 8'd7, 8'd7, 1'b0, 1, 1'b0, 1'b1, 8'h01, 1);
    endtask

    task automatic test_timeout();
        run_op(8'd5, 8'd9, 8'h77, 8'h01, 1'b0, 1000, 1'b0, 1'b1, 8'hAA, 0);
    endtask

    task automatic test_boundary();
        run_op(8'd7, 8'd1, 8'd1, 8'd1, 1'b0, 1, 1'b0, 1'b1, 8'h3C, 0);       // minimum latency
        run_op(8'd2, 8'd4, 8'd4, 8'd4, 1'b1, TMO - 1, 1'b0, 1'b1, 8'h99, 0); // opdone on timeout cycle
        run_op(8'd1, 8'd6, 8'd6, 8'd6, 1'b0, 3, 1'b1, 1'b0, 8'h42, 0);       // stale opdone in ISSUE
    endtask

    task automatic test_backpressure();
        run_op(8'd4, 8'h10, 8'h20, 8'h30, 1'b1, 2, 1'b0, 1'b1, 8'h66, 5);
        run_op(8'd6, 8'h01, 8'h02, 8'h03, 1'b0, 1, 1'b0, 1'b0, 8'h07, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [7:0] op;
            int         k;
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            k  = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(1, TMO);
            run_op(op, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), k,
                   1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3));
        end
    endtask

`ifdef ESFA_SEQ_STATS_EN
    task automatic test_stats();
        checks++;
        if (stat_ops !== 16'(exp_ops) || stat_timeouts !== 8'(exp_tmo)) begin
            errors++;
            $display("FAIL stats got ops=%0d tmo=%0d want ops=%0d tmo=%0d",
                     stat_ops, stat_timeouts, exp_ops, exp_tmo);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 8'd3;
        bus.cmd_index = 8'h44;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b1 || bus.arr_selector !== 8'd3) begin
            errors++;
            $display("FAIL mid_wait_active got busy=%b sel=%0d want 1 3", bus.busy, bus.arr_selector);
        end
        reset = 1'b0;
        exp_ops = 0;
        exp_tmo = 0;
        #1;
        check_idle_lines("reset_mid_wait_arr");
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait got busy=%b rsp_valid=%b want 0 0", bus.busy, bus.rsp_valid);
        end
`ifdef ESFA_SEQ_STATS_EN
        test_stats();
`endif
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_quiet got rsp_valid=%b cmd_ready=%b want 0 1",
                         bus.rsp_valid, bus.cmd_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_random();
`ifdef ESFA_SEQ_STATS_EN
        test_stats();
`endif
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
